// File: rtl/pipelined_addsub.sv
// Segmented, pipelined two's-complement adder/subtractor with valid/ready flow control.
// Define ADDSUB_SATURATE_EN to clamp the result on signed overflow instead of wrapping.
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NSEG  = WIDTH / SEG;
    localparam int LAST  = NSEG - 1;
    localparam int NPIPE = (NSEG > 1) ? NSEG - 1 : 1;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Inter-stage registers: stage k holds its own carry, the finished low result
    // segments (deskew) and the full operands so upper segments ride along (skew).
    logic             r_v  [NPIPE];
    logic             r_op [NPIPE];
    logic             r_c  [NPIPE];
    logic [WIDTH-1:0] r_a  [NPIPE];
    logic [WIDTH-1:0] r_b  [NPIPE];
    logic [WIDTH-1:0] r_s  [NPIPE];

    logic             r_out_valid;
    logic [WIDTH-1:0] r_s_out;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    logic             w_v_in  [NSEG];
    logic             w_op_in [NSEG];
    logic             w_c_in  [NSEG];
    logic [WIDTH-1:0] w_a_in  [NSEG];
    logic [WIDTH-1:0] w_b_in  [NSEG];
    logic [WIDTH-1:0] w_p_in  [NSEG];
    logic             w_c_out [NSEG];
    logic [WIDTH-1:0] w_p_out [NSEG];
    logic [SEG:0]     w_seg;

    logic             w_advance;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_cout;
    logic             w_zero;
    logic             w_neg;

    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    assign out_valid = r_out_valid;
    assign s         = r_s_out;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign neg       = r_neg;

    // Per-stage segment adders; subtraction enters as a + ~b + ~borrow at stage 0.
    always_comb begin
        w_v_in[0]  = in_valid;
        w_op_in[0] = op;
        w_c_in[0]  = cin ^ op;
        w_a_in[0]  = a;
        w_b_in[0]  = op ? ~b : b;
        w_p_in[0]  = '0;
        for (int k = 1; k < NSEG; k++) begin
            w_v_in[k]  = r_v[k-1];
            w_op_in[k] = r_op[k-1];
            w_c_in[k]  = r_c[k-1];
            w_a_in[k]  = r_a[k-1];
            w_b_in[k]  = r_b[k-1];
            w_p_in[k]  = r_s[k-1];
        end
        w_seg = '0;
        for (int k = 0; k < NSEG; k++) begin
            w_seg = {1'b0, w_a_in[k][k*SEG +: SEG]}
                  + {1'b0, w_b_in[k][k*SEG +: SEG]}
                  + {{SEG{1'b0}}, w_c_in[k]};
            w_c_out[k]                  = w_seg[SEG];
            w_p_out[k]                  = w_p_in[k];
            w_p_out[k][k*SEG +: SEG]    = w_seg[SEG-1:0];
        end
    end

    // Final-stage result and flags; overflow is same-sign operands giving a different-sign sum.
    always_comb begin
        w_sum  = w_p_out[LAST];
        w_cout = w_c_out[LAST] ^ w_op_in[LAST];
        w_ovf  = (w_a_in[LAST][WIDTH-1] == w_b_in[LAST][WIDTH-1]) &&
                 (w_sum[WIDTH-1] != w_a_in[LAST][WIDTH-1]);
`ifdef ADDSUB_SATURATE_EN
        if (w_ovf) begin
            w_res = w_a_in[LAST][WIDTH-1] ? SAT_MIN : SAT_MAX;
        end else begin
            w_res = w_sum;
        end
`else
        w_res = w_sum;
`endif
        w_zero = (w_res == {WIDTH{1'b0}});
        w_neg  = w_res[WIDTH-1];
    end

    // Pipeline shift on advance; everything freezes while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NPIPE; k++) begin
                r_v[k]  <= 1'b0;
                r_op[k] <= 1'b0;
                r_c[k]  <= 1'b0;
                r_a[k]  <= '0;
                r_b[k]  <= '0;
                r_s[k]  <= '0;
            end
            r_out_valid <= 1'b0;
            r_s_out     <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
        end else if (w_advance) begin
            for (int k = 0; k < NSEG - 1; k++) begin
                r_v[k]  <= w_v_in[k];
                r_op[k] <= w_op_in[k];
                r_c[k]  <= w_c_out[k];
                r_a[k]  <= w_a_in[k];
                r_b[k]  <= w_b_in[k];
                r_s[k]  <= w_p_out[k];
            end
            r_out_valid <= w_v_in[LAST];
            r_s_out     <= w_res;
            r_cout      <= w_cout;
            r_ovf       <= w_ovf;
            r_zero      <= w_zero;
            r_neg       <= w_neg;
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub at WIDTH=16, SEG=4 (latency 4).
module tb_pipelined_addsub;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;

    int n_checks = 0;
    int n_pass   = 0;

    pipelined_addsub #(.WIDTH(16), .SEG(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .cout     (cout),
        .ovf      (ovf),
        .zero     (zero),
        .neg      (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation through an empty pipeline: checks latency, result and flags.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                          input logic top, input logic [15:0] es, input logic ec,
                          input logic eo, input logic ez, input logic en, input string tag);
        int n;
        n = 1;
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; op = top; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        while (n <= 12) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) break;
            @(posedge clk);
            n++;
        end
        check_val({tag, "_lat"}, 32'(n), 32'd4);
        check_val({tag, "_s"}, {16'h0, s}, {16'h0, es});
        check_val({tag, "_flags"}, {28'h0, cout, ovf, zero, neg}, {28'h0, ec, eo, ez, en});
    endtask

    function automatic logic [15:0] bp_a(input int i);
        return 16'(16'h1000 * i + 16'h0123);
    endfunction

    function automatic logic [15:0] bp_b(input int i);
        return 16'(16'h0F0F + i);
    endfunction

    initial begin
        logic [15:0] exp_q [6];
        logic [3:0]  pat;
        int sent, got, stall_left;
        bit stalled_once;

        rst_n = 1'b0; in_valid = 1'b0; a = 16'h0; b = 16'h0;
        cin = 1'b0; op = 1'b0; out_ready = 1'b1;
        #1;
        check_val("rst_outs", {16'h0, s, 3'b0, out_valid, cout, ovf, zero, neg},
                  {16'h0, 16'h0, 3'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        check_val("rst_in_ready", {31'h0, in_ready}, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0, "add");
`ifdef ADDSUB_SATURATE_EN
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, "add_ovf");
`else
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, "add_ovf");
`endif
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1, "sub_borrow");
`ifdef ADDSUB_SATURATE_EN
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, "sub_ovf");
`else
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, "sub_ovf");
`endif
        run_op(16'h1111, 16'h1111, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, "sub_zero");
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, "add_cin");
        run_op(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b0, 1'b0, 1'b0, 1'b0, "sub_bin");

        // Backpressure: six back-to-back adds, consumer stalls 3 cycles on the first result.
        for (int i = 0; i < 6; i++) exp_q[i] = 16'(bp_a(i) + bp_b(i));
        sent = 0; got = 0; stall_left = 0; stalled_once = 1'b0;
        cin = 1'b0; op = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            @(negedge clk);
            if (out_valid && !stalled_once) begin
                stall_left = 3;
                stalled_once = 1'b1;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            in_valid = (sent < 6);
            a = bp_a(sent);
            b = bp_b(sent);
            #1;
            if (!out_ready) begin
                check_val("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
                check_val("bp_hold_valid", {31'h0, out_valid}, 32'h1);
                check_val("bp_hold_s", {16'h0, s}, {16'h0, exp_q[got]});
            end
            if (out_valid && out_ready) begin
                check_val($sformatf("bp_res%0d", got), {16'h0, s}, {16'h0, exp_q[got]});
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        check_val("bp_count", 32'(got), 32'd6);
        check_val("bp_stalled", {31'h0, stalled_once}, 32'h1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check_val("bp_no_dup", {31'h0, out_valid}, 32'h0);

        // Bubbles: in_valid 1,0,1,0 reappears on out_valid four cycles later.
        pat = 4'b0101;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (cyc < 4) begin
                check_val($sformatf("bub_idle%0d", cyc), {31'h0, out_valid}, 32'h0);
            end else begin
                check_val($sformatf("bub_out%0d", cyc - 4), {31'h0, out_valid},
                          {31'h0, pat[cyc - 4]});
            end
            in_valid = (cyc < 4) ? pat[cyc] : 1'b0;
            a = 16'(16'h0100 * cyc); b = 16'h0001;
        end

        repeat (4) @(negedge clk);
        // Reset mid-flight: one result at the output, three more behind it.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'(16'h0101 * (i + 1)); b = 16'h7FFF; cin = 1'b0; op = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_val("rst_pre_valid", {31'h0, out_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_outs", {16'h0, s, 3'b0, out_valid, cout, ovf, zero, neg}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val($sformatf("rst_flush%0d", i), {31'h0, out_valid}, 32'h0);
        end
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
